// File: rtl/crc3_checker.sv
// Serial CRC-3 frame checker: captures MSG_W message bits plus CRC_W check bits, MSB-first.
// Results update on the edge that accepts the last bit. Frames may be gapped, aborted or sent back-to-back.
module crc3_checker #(
  parameter int MSG_W = 5,
  parameter int CRC_W = 3
) (
  input  logic                     gated_clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_bit,
  input  logic                     abort,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     crc_ok,
  output logic [CRC_W-1:0]         syndrome,
  output logic [MSG_W+CRC_W-1:0]   codeword,
  output logic [MSG_W-1:0]         msg_out,
  output logic [7:0]               err_count
);

  localparam int FRAME_W = MSG_W + CRC_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] MSG_END  = CNT_W'(MSG_W);

  typedef enum logic {IDLE, RECV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [FRAME_W-2:0] shift_reg;
  logic [CRC_W-1:0]   lfsr;
  logic [CRC_W-1:0]   rx_crc;

  logic               in_msg;
  logic               feed;
  logic [CRC_W-1:0]   lfsr_cur;
  logic [CRC_W-1:0]   lfsr_next;
  logic [CRC_W-1:0]   rx_crc_next;
  logic [CRC_W-1:0]   syndrome_next;
  logic               last_bit;

  // A new frame always starts from a cleared LFSR, whatever IDLE left behind.
  always_comb begin
    in_msg        = (count < MSG_END);
    feed          = in_msg ? in_bit : 1'b0;
    lfsr_cur      = (state == IDLE) ? '0 : lfsr;
    lfsr_next     = {lfsr_cur[CRC_W-2:0], feed ^ lfsr_cur[0] ^ lfsr_cur[CRC_W-1]};
    rx_crc_next   = in_msg ? rx_crc : {rx_crc[CRC_W-2:0], in_bit};
    syndrome_next = lfsr_next ^ rx_crc_next;
    last_bit      = (count == LAST_CNT);
  end

  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      shift_reg  <= '0;
      lfsr       <= '0;
      rx_crc     <= '0;
      codeword   <= '0;
      syndrome   <= '0;
      crc_ok     <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        count     <= '0;
        shift_reg <= '0;
        lfsr      <= '0;
        rx_crc    <= '0;
      end else if (in_valid) begin
        if (last_bit) begin
          codeword   <= {shift_reg, in_bit};
          syndrome   <= syndrome_next;
          crc_ok     <= (syndrome_next == '0);
          frame_done <= 1'b1;
          if ((syndrome_next != '0) && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
          state      <= IDLE;
          count      <= '0;
          shift_reg  <= '0;
          lfsr       <= '0;
          rx_crc     <= '0;
        end else begin
          state     <= RECV;
          count     <= count + CNT_W'(1);
          shift_reg <= {shift_reg[FRAME_W-3:0], in_bit};
          lfsr      <= lfsr_next;
          rx_crc    <= rx_crc_next;
        end
      end
    end
  end

  assign busy    = (count != '0);
  assign msg_out = codeword[FRAME_W-1 -: MSG_W];

endmodule

// File: tb/tb_crc3_checker.sv
// Directed bench for crc3_checker: hand-computed codewords, syndromes and error counts.
module tb_crc3_checker;

  logic       gated_clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       abort;
  logic       busy;
  logic       frame_done;
  logic       crc_ok;
  logic [2:0] syndrome;
  logic [7:0] codeword;
  logic [4:0] msg_out;
  logic [7:0] err_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int done_cnt = 0;
  int done_base;

  crc3_checker dut (
    .gated_clk  (gated_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .abort      (abort),
    .busy       (busy),
    .frame_done (frame_done),
    .crc_ok     (crc_ok),
    .syndrome   (syndrome),
    .codeword   (codeword),
    .msg_out    (msg_out),
    .err_count  (err_count)
  );

  always #5 gated_clk = ~gated_clk;

  always @(negedge gated_clk)
    if (frame_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    chk_cnt++;
    if (observed === expected) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
  endtask

  // Drives one accepted bit just after an edge and returns 1ns after the capturing edge.
  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    abort    = 1'b0;
    @(posedge gated_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    abort    = 1'b0;
    repeat (n) begin
      @(posedge gated_clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int first, input int last);
    for (int i = first; i <= last; i++) send_bit(v[7-i]);
  endtask

  task automatic send_frame(input logic [7:0] v);
    send_bits(v, 0, 7);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    abort    = 1'b0;
    #12;
    check("rst_busy",     {31'd0, busy},       32'd0);
    check("rst_done",     {31'd0, frame_done}, 32'd0);
    check("rst_crc_ok",   {31'd0, crc_ok},     32'd0);
    check("rst_codeword", {24'd0, codeword},   32'd0);
    check("rst_err",      {24'd0, err_count},  32'd0);
    @(negedge gated_clk);
    reset = 1'b0;
    @(posedge gated_clk);
    #1;

    // Good frame 0xB6: message 10110, CRC 110.
    send_bits(8'hB6, 0, 6);
    check("busy_mid",   {31'd0, busy},       32'd1);
    check("done_early", {31'd0, frame_done}, 32'd0);
    send_bit(1'b0);
    check("good_done",     {31'd0, frame_done}, 32'd1);
    check("good_codeword", {24'd0, codeword},   32'hB6);
    check("good_msg",      {27'd0, msg_out},    32'b10110);
    check("good_syn",      {29'd0, syndrome},   32'd0);
    check("good_ok",       {31'd0, crc_ok},     32'd1);
    check("good_err",      {24'd0, err_count},  32'd0);
    check("good_busy",     {31'd0, busy},       32'd0);
    idle_cycles(1);
    check("done_one_cyc", {31'd0, frame_done}, 32'd0);
    check("hold_codeword", {24'd0, codeword},  32'hB6);

    // Bit error 0xB7, then 0x0E back-to-back.
    send_frame(8'hB7);
    check("bad_syn",  {29'd0, syndrome},  32'd1);
    check("bad_ok",   {31'd0, crc_ok},    32'd0);
    check("bad_err",  {24'd0, err_count}, 32'd1);
    send_frame(8'h0E);
    check("b2b_codeword", {24'd0, codeword},  32'h0E);
    check("b2b_ok",       {31'd0, crc_ok},    32'd1);
    check("b2b_syn",      {29'd0, syndrome},  32'd0);
    check("b2b_err",      {24'd0, err_count}, 32'd1);

    // 0x00 with a three-cycle gap mid-frame.
    send_bits(8'h00, 0, 3);
    idle_cycles(3);
    check("gap_busy", {31'd0, busy}, 32'd1);
    send_bits(8'h00, 4, 7);
    check("gap_codeword", {24'd0, codeword}, 32'h00);
    check("gap_ok",       {31'd0, crc_ok},   32'd1);

    // Abort after 4 bits, then a clean 0xB6.
    idle_cycles(1);
    done_base = done_cnt;
    send_bits(8'hFF, 0, 3);
    abort = 1'b1;
    @(posedge gated_clk);
    #1;
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    send_frame(8'hB6);
    idle_cycles(1);
    check("abort_one_done", done_cnt - done_base, 32'd1);
    check("abort_codeword", {24'd0, codeword},    32'hB6);

    // Abort coinciding with the 8th bit: no completion, results held.
    send_bits(8'hB7, 0, 6);
    done_base = done_cnt;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    abort    = 1'b1;
    @(posedge gated_clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    check("abort8_done",     {31'd0, frame_done}, 32'd0);
    check("abort8_busy",     {31'd0, busy},       32'd0);
    check("abort8_codeword", {24'd0, codeword},   32'hB6);
    check("abort8_err",      {24'd0, err_count},  32'd1);
    idle_cycles(2);
    check("abort8_no_pulse", done_cnt - done_base, 32'd0);

    // Reset after 5 bits of a frame.
    send_bits(8'hB7, 0, 4);
    #2;
    reset = 1'b1;
    #1;
    check("mrst_busy",     {31'd0, busy},       32'd0);
    check("mrst_codeword", {24'd0, codeword},   32'd0);
    check("mrst_syn",      {29'd0, syndrome},   32'd0);
    check("mrst_ok",       {31'd0, crc_ok},     32'd0);
    check("mrst_err",      {24'd0, err_count},  32'd0);
    check("mrst_msg",      {27'd0, msg_out},    32'd0);
    @(negedge gated_clk);
    reset = 1'b0;
    @(posedge gated_clk);
    #1;
    send_frame(8'h0E);
    check("post_rst_codeword", {24'd0, codeword}, 32'h0E);
    check("post_rst_ok",       {31'd0, crc_ok},   32'd1);

    // Saturation: 256 bad frames from a zero count.
    for (int n = 1; n <= 256; n++) begin
      send_frame(8'hB7);
      if (n == 1)   check("sat_first", {24'd0, err_count}, 32'd1);
      if (n == 255) check("sat_255",   {24'd0, err_count}, 32'd255);
      if (n == 256) check("sat_hold",  {24'd0, err_count}, 32'd255);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
